// File: rtl/result_unloader.sv
// rtl/result_unloader.sv - streams the N*N result matrix from BRAM C as a row-major valid/ready stream
//
// Purpose: after a start pulse (normally the compute unit's done), reads BRAM C
// one word per cycle and forwards the words in address order to the egress path.
// A small FIFO absorbs the 1-cycle BRAM read latency and downstream backpressure.
// Reads are only issued while the FIFO plus the in-flight read leave room, so the
// FIFO cannot overflow.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   start           one-cycle unload request, honoured only in IDLE
//   busy, done      transfer in progress / one-cycle completion pulse
//   bram_addr/rden  BRAM C read port; bram_q valid one cycle after rden
//   m_valid/ready   output stream handshake
//   m_data, m_last  output word, high on element N*N-1 only

module result_unloader #(
  parameter int N          = 16,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = $clog2(N * N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_rden,
  input  logic [DATA_W-1:0] bram_q,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_W:0]  TOTAL     = (ADDR_W + 1)'(N * N);
  localparam logic [ADDR_W:0]  LAST_IDX  = (ADDR_W + 1)'(N * N - 1);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FINISH
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W:0]   beat_cnt;
  logic              inflight;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              credit_ok;
  logic              issue;
  logic              push;
  logic              pop;

  // Credit uses the count before this cycle's pop: one cycle of slack is given
  // up so the issue decision never depends on m_ready.
  assign credit_ok  = ({1'b0, fifo_count} + (CNT_W + 1)'(inflight)) < DEPTH_EXT;
  assign fifo_empty = (fifo_count == '0);
  assign push       = inflight;
  assign pop        = m_valid && m_ready;

  assign m_valid = !fifo_empty;
  assign m_data  = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign m_last  = m_valid && (beat_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    bram_rden = 1'b0;
    bram_addr = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = READ;
      end
      READ: begin
        busy  = 1'b1;
        issue = (rd_cnt < TOTAL) && credit_ok;
        if (issue) begin
          bram_rden = 1'b1;
          bram_addr = rd_cnt[ADDR_W-1:0];
          if (rd_cnt == LAST_IDX) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && m_last) state_nxt = FINISH;
      end
      FINISH: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters restart in IDLE so every transfer begins at element 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt   <= '0;
      beat_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (state == IDLE) begin
        rd_cnt   <= '0;
        beat_cnt <= '0;
      end else begin
        if (issue) rd_cnt <= rd_cnt + 1'b1;
        if (pop) beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible while fifo_count > 0.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bram_q;
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (fifo_count == DEPTH_CNT)));

endmodule

// File: tb/tb_result_unloader.sv
// tb/tb_result_unloader.sv - directed self-checking bench for result_unloader
module tb_result_unloader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  bram_addr;
  logic        bram_rden;
  logic [31:0] bram_q;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  logic        s_start;
  logic        s_busy;
  logic        s_done;
  logic [1:0]  s_bram_addr;
  logic        s_bram_rden;
  logic [31:0] s_bram_q;
  logic        s_m_valid;
  logic        s_m_ready;
  logic [31:0] s_m_data;
  logic        s_m_last;

  int vectors = 0;
  int errors  = 0;

  result_unloader #(.N(16), .DATA_W(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .bram_addr(bram_addr), .bram_rden(bram_rden), .bram_q(bram_q),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  result_unloader #(.N(2), .DATA_W(32), .FIFO_DEPTH(2)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .bram_addr(s_bram_addr), .bram_rden(s_bram_rden), .bram_q(s_bram_q),
    .m_valid(s_m_valid), .m_ready(s_m_ready), .m_data(s_m_data), .m_last(s_m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM C models: word[i] = i*3+7, one-cycle registered read.
  always @(posedge clk) begin
    if (bram_rden) bram_q <= 32'(bram_addr) * 32'd3 + 32'd7;
    if (s_bram_rden) s_bram_q <= 32'(s_bram_addr) * 32'd3 + 32'd7;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; m_ready = 1'b0; s_start = 1'b0; s_m_ready = 1'b0;
    bram_q = '0; s_bram_q = '0;
    repeat (2) step();
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (bram_addr !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", bram_addr); end
    vectors++; if (bram_rden !== 1'b0) begin errors++; $display("FAIL reset_rden: got %b expected 0", bram_rden); end
    vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
    vectors++; if (m_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", m_data); end
    vectors++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", m_last); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    int beat = 0;
    int dones = 0;
    m_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      vectors++;
      if (busy !== ((c >= 1 && c <= 259) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL b2b_busy cycle %0d: got %b", c, busy);
      end
      if (c == 1) begin
        vectors++;
        if (bram_rden !== 1'b1 || bram_addr !== 8'd0) begin
          errors++; $display("FAIL b2b_first_read: got rden %b addr %0d expected 1 0", bram_rden, bram_addr);
        end
      end
      if (m_valid && m_ready) begin
        if (beat == 0) begin
          vectors++;
          if (c != 3) begin errors++; $display("FAIL b2b_first_valid: got cycle %0d expected 3", c); end
        end
        vectors++;
        if (m_data !== 32'(beat * 3 + 7)) begin
          errors++; $display("FAIL b2b_data beat %0d: got %0d expected %0d", beat, m_data, beat * 3 + 7);
        end
        vectors++;
        if (m_last !== ((beat == 255) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL b2b_last beat %0d: got %b", beat, m_last);
        end
        beat++;
      end
      if (done === 1'b1) begin
        dones++;
        vectors++;
        if (c != 259) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 259", c); end
      end
      step();
    end
    vectors++; if (beat != 256) begin errors++; $display("FAIL b2b_beats: got %0d expected 256", beat); end
    vectors++; if (dones != 1) begin errors++; $display("FAIL b2b_dones: got %0d expected 1", dones); end
  endtask

  task automatic test_backpressure();
    int beat = 0;
    int dones = 0;
    int issued = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic prev_last = 1'b0;
    m_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 3000 && dones == 0; c++) begin
      m_ready = ($urandom_range(0, 9) < 3);
      #0;
      if (prev_stall) begin
        vectors++;
        if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
          errors++; $display("FAIL bp_stable cycle %0d: got v %b d %0d expected v 1 d %0d", c, m_valid, m_data, prev_data);
        end
      end
      if (bram_rden) issued++;
      vectors++;
      if (issued - beat > 4) begin
        errors++; $display("FAIL bp_outstanding cycle %0d: got %0d expected <= 4", c, issued - beat);
      end
      if (m_valid && m_ready) begin
        vectors++;
        if (m_data !== 32'(beat * 3 + 7) || m_last !== ((beat == 255) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL bp_data beat %0d: got %0d last %b expected %0d", beat, m_data, m_last, beat * 3 + 7);
        end
        beat++;
      end
      if (done === 1'b1) dones++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      step();
    end
    vectors++; if (beat != 256) begin errors++; $display("FAIL bp_beats: got %0d expected 256", beat); end
    vectors++; if (dones != 1) begin errors++; $display("FAIL bp_done: got %0d expected 1", dones); end
    m_ready = 1'b0;
    step();
  endtask

  task automatic test_full_stall();
    int beat = 0;
    int dones = 0;
    int issued = 0;
    m_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (bram_rden) issued++;
      step();
    end
    vectors++; if (issued != 4) begin errors++; $display("FAIL stall_reads: got %0d expected 4", issued); end
    vectors++; if (bram_rden !== 1'b0) begin errors++; $display("FAIL stall_rden: got %b expected 0", bram_rden); end
    vectors++; if (m_valid !== 1'b1 || m_data !== 32'd7) begin
      errors++; $display("FAIL stall_head: got v %b d %0d expected v 1 d 7", m_valid, m_data);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (bram_rden) issued++;
      if (m_valid && m_ready) begin
        vectors++;
        if (m_data !== 32'(beat * 3 + 7)) begin
          errors++; $display("FAIL stall_data beat %0d: got %0d expected %0d", beat, m_data, beat * 3 + 7);
        end
        beat++;
      end
      if (done === 1'b1) dones++;
      step();
    end
    vectors++; if (beat != 256) begin errors++; $display("FAIL stall_beats: got %0d expected 256", beat); end
    vectors++; if (issued != 256) begin errors++; $display("FAIL stall_total_reads: got %0d expected 256", issued); end
    vectors++; if (dones != 1) begin errors++; $display("FAIL stall_done: got %0d expected 1", dones); end
  endtask

  task automatic test_start_while_busy();
    int beat = 0;
    int dones = 0;
    logic sent = 1'b0;
    m_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      start = (beat == 100 && !sent);
      if (start) sent = 1'b1;
      if (m_valid && m_ready) begin
        vectors++;
        if (m_data !== 32'(beat * 3 + 7)) begin
          errors++; $display("FAIL sb_data beat %0d: got %0d expected %0d", beat, m_data, beat * 3 + 7);
        end
        beat++;
      end
      if (done === 1'b1) dones++;
      step();
    end
    start = 1'b0;
    vectors++; if (beat != 256) begin errors++; $display("FAIL sb_beats: got %0d expected 256", beat); end
    vectors++; if (dones != 1) begin errors++; $display("FAIL sb_dones: got %0d expected 1", dones); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL sb_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int beat = 0;
    int dones = 0;
    m_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 200 && beat < 50; c++) begin
      if (m_valid && m_ready) beat++;
      step();
    end
    vectors++; if (beat != 50) begin errors++; $display("FAIL rm_reach50: got %0d expected 50", beat); end
    rst = 1'b0;
    #1;
    vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", m_valid); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", busy); end
    vectors++; if (bram_rden !== 1'b0) begin errors++; $display("FAIL rm_rden: got %b expected 0", bram_rden); end
    step();
    rst = 1'b1;
    step();
    beat = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (m_valid && m_ready) begin
        vectors++;
        if (m_data !== 32'(beat * 3 + 7)) begin
          errors++; $display("FAIL rm_data beat %0d: got %0d expected %0d", beat, m_data, beat * 3 + 7);
        end
        beat++;
      end
      if (done === 1'b1) dones++;
      step();
    end
    vectors++; if (beat != 256) begin errors++; $display("FAIL rm_beats: got %0d expected 256", beat); end
    vectors++; if (dones != 1) begin errors++; $display("FAIL rm_dones: got %0d expected 1", dones); end
  endtask

  task automatic test_small_config();
    int beat = 0;
    int dones = 0;
    s_m_ready = 1'b0;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      s_m_ready = c[0];
      #0;
      if (s_m_valid && s_m_ready) begin
        vectors++;
        if (s_m_data !== 32'(beat * 3 + 7) || s_m_last !== ((beat == 3) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL small_beat %0d: got %0d last %b expected %0d", beat, s_m_data, s_m_last, beat * 3 + 7);
        end
        beat++;
      end
      if (s_done === 1'b1) dones++;
      step();
    end
    vectors++; if (beat != 4) begin errors++; $display("FAIL small_beats: got %0d expected 4", beat); end
    vectors++; if (dones != 1) begin errors++; $display("FAIL small_dones: got %0d expected 1", dones); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_full_stall();
    test_start_while_busy();
    test_reset_mid();
    test_small_config();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/result_unloader.md
# result_unloader

Streams the N×N result matrix out of result memory C after the systolic compute unit finishes, as a row-major valid/ready stream to the host-side egress path. It is the read-side counterpart to the compute unit's store phase. It issues one read per cycle on a single BRAM C port and absorbs the 1-cycle BRAM read latency and downstream backpressure with a small credit-managed FIFO. A `start` pulse, normally the compute unit's `done`, triggers one full matrix transfer.

## Interface
- `N`, 16: matrix dimension; the transfer length is N*N words.
- `DATA_W`, 32: result word width; matches BRAM C.
- `FIFO_DEPTH`, 4: output buffer entries; must be ≥ 2.
- `ADDR_W`, $clog2(N*N): BRAM C address width; derived, not overridden.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to unload a matrix; ignored unless the block is IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`, inclusive.
- `done`  out  1  one-cycle pulse after the last word is accepted downstream.
- `bram_addr`  out  ADDR_W  BRAM C port read address.
- `bram_rden`  out  1  read issue strobe; `bram_q` is valid exactly 1 cycle later.
- `bram_q`  in  DATA_W  BRAM C read data.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DATA_W  result word; the k-th beat carries element [k/N][k%N].
- `m_last`  out  1  high with the N*N-1-th beat only.

## Operation
- FSM states: IDLE → READ → DRAIN → FINISH → IDLE.
- IDLE: the read counter (ADDR_W+1 bits) is cleared. `start` moves the FSM to READ.
- READ: the block issues a read when `rd_cnt < N*N` and `fifo_count + inflight < FIFO_DEPTH`.
  - `inflight` is 1 if a read was issued in the previous cycle.
  - `fifo_count` is the value before this cycle's pop; this is deliberately conservative.
  - On issue: `bram_addr = rd_cnt[ADDR_W-1:0]`, `bram_rden = 1`, and `rd_cnt` increments.
  - When the last address (N*N-1) is issued, the FSM moves to DRAIN.
- Data capture: a registered copy of `bram_rden` writes `bram_q` into the FIFO. The FIFO can never overflow under the credit rule; overflow is an assertion failure.
- Output: `m_valid = !fifo_empty` and `m_data = fifo_head`.
  - A pop occurs on `m_valid && m_ready`.
  - `m_last` is high when the head entry is the element with index N*N-1. This is tracked by an output beat counter, not by address.
- DRAIN: the FSM waits for the beat with `m_last` to be accepted, then moves to FINISH.
- FINISH: `done = 1` for one cycle, then the FSM returns to IDLE.
- A simultaneous FIFO push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- `start` while `busy` is ignored; no queuing.
- Output stability: `m_data` and `m_last` hold while `m_valid && !m_ready`. `m_valid` never drops without a handshake.
- Reset mid-transfer: the FSM goes to IDLE, the FIFO empties, and all counters clear. No partial stream resumes.

## Timing
- Reset values: `busy` 0, `done` 0, `bram_addr` 0, `bram_rden` 0, `m_valid` 0, `m_data` 0, `m_last` 0.
- Cycle 0: `start` sampled high in IDLE.
- Cycle 1: READ state, `busy` = 1, `bram_rden` = 1 with `bram_addr` = 0.
- Cycle 2: `bram_q` holds word 0 and is pushed into the FIFO at the end of the cycle.
- Cycle 3: first `m_valid`. Latency from `start` to first `m_valid` is 3 cycles.
- Throughput: with `m_ready` held high, one beat per cycle with no bubbles. The last beat is at cycle N*N+2 and `done` at cycle N*N+3 (259 for N=16).
- `done` asserts the cycle after the `m_last` handshake; `busy` falls with `done` deasserting.
- Backpressure: at most FIFO_DEPTH reads are outstanding in the FIFO plus in flight. `bram_rden` stays low while no credit is available.

## Test plan
- Back-to-back stream: BRAM C preloaded with word[i] = i*3+7, N=16, `m_ready` = 1, pulse `start` → 256 beats with values 7, 10, …, 772 in order. First `m_valid` at cycle 3, `m_last` only on beat 255, `done` at cycle 259, `busy` high for cycles 1–259.
- Random backpressure: `m_ready` driven by a 30% duty random pattern → identical 256-word sequence with no drops or duplicates. `m_data` stable across stalls; FIFO count never exceeds 4 and the overflow assertion never fires.
- Full stall: hold `m_ready` = 0 after `start` → exactly 4 reads issued, then `bram_rden` stays 0. Release `m_ready` → resumes from word 0 in order.
- Start while busy: a second `start` pulse at beat 100 → ignored; exactly 256 beats and exactly one `done`.
- Reset mid-transfer: assert `rst` low at beat 50 → `m_valid`, `busy` and `bram_rden` go to 0 immediately. A fresh `start` then streams from word 0 with a full 256 beats.
- Small config: N=2, FIFO_DEPTH=2, `m_ready` toggling every cycle → beats 0–3 in order, `m_last` on beat 3, one `done` pulse.
